// File: rtl/adder_pkg.sv
// Shared constants, operation encoding and stage-1 payload type for the
// pipelined carry-select adder.
package adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_BLK   = 8;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Sign bits carried beside the partial sums so stage 2 can form overflow
    typedef struct packed {
        logic sign_a;
        logic sign_b;
    } s1_meta_t;

endpackage

// File: rtl/select_block.sv
// One carry-select slice: the same BLK-bit operands added twice, once
// assuming carry-in 0 and once assuming carry-in 1.
module select_block #(
    parameter int BLK = 8
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    output logic [BLK-1:0] sum0,
    output logic [BLK-1:0] sum1,
    output logic           c0,
    output logic           c1
);

    assign {c0, sum0} = {1'b0, a} + {1'b0, b};
    assign {c1, sum1} = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};

endmodule

// File: rtl/pipelined_select_adder.sv
// Two-stage valid/ready carry-select adder/subtractor with overflow flag.
// Optional saturation of s on overflow: define PIPELINED_SELECT_ADDER_SAT_EN.
module pipelined_select_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLK   = DEF_BLK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             of
);

    localparam int NBLK = WIDTH / BLK;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [BLK:0]     lo_sum;
    logic [WIDTH-1:BLK] hi_sum0;
    logic [WIDTH-1:BLK] hi_sum1;
    logic [NBLK-1:1]    hi_c0;
    logic [NBLK-1:1]    hi_c1;

    always_comb begin
        b_eff   = (op_e'(sub) == OP_SUB) ? ~b : b;
        cin_eff = (op_e'(sub) == OP_SUB) ? 1'b1 : cin;
    end

    // Block 0 sees the real carry-in, so only one sum is needed
    assign lo_sum = {1'b0, a[BLK-1:0]} + {1'b0, b_eff[BLK-1:0]} + {{BLK{1'b0}}, cin_eff};

    for (genvar k = 1; k < NBLK; k++) begin : g_blk
        select_block #(
            .BLK (BLK)
        ) u_blk (
            .a    (a[k*BLK +: BLK]),
            .b    (b_eff[k*BLK +: BLK]),
            .sum0 (hi_sum0[k*BLK +: BLK]),
            .sum1 (hi_sum1[k*BLK +: BLK]),
            .c0   (hi_c0[k]),
            .c1   (hi_c1[k])
        );
    end

    logic vld_p1;
    logic vld_p2;
    logic s2_free;

    assign s2_free  = !vld_p2 || out_ready;
    assign in_ready = rst_n && (!vld_p1 || s2_free);

    // ---- stage 1: block-local sums for both carry assumptions ----
    logic [BLK-1:0]     lo_sum_p1;
    logic               lo_c_p1;
    logic [WIDTH-1:BLK] hi_sum0_p1;
    logic [WIDTH-1:BLK] hi_sum1_p1;
    logic [NBLK-1:1]    hi_c0_p1;
    logic [NBLK-1:1]    hi_c1_p1;
    s1_meta_t           meta_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            lo_sum_p1      <= lo_sum[BLK-1:0];
            lo_c_p1        <= lo_sum[BLK];
            hi_sum0_p1     <= hi_sum0;
            hi_sum1_p1     <= hi_sum1;
            hi_c0_p1       <= hi_c0;
            hi_c1_p1       <= hi_c1;
            meta_p1.sign_a <= a[WIDTH-1];
            meta_p1.sign_b <= b_eff[WIDTH-1];
        end
    end

`ifdef PIPELINED_SELECT_ADDER_SAT_EN
    function automatic logic [WIDTH-1:0] saturate(
        input logic [WIDTH-1:0] raw,
        input logic             ovf,
        input logic             neg
    );
        if (!ovf) begin
            return raw;
        end
        return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    logic signed [WIDTH-1:0] s_raw;
    logic [WIDTH-1:0]        s_fin;
    logic                    carry;
    logic                    of_raw;

    // Select chain ripples one mux per block from block 0 upward
    always_comb begin
        s_raw          = '0;
        carry          = lo_c_p1;
        s_raw[BLK-1:0] = lo_sum_p1;
        for (int k = 1; k < NBLK; k++) begin
            s_raw[k*BLK +: BLK] = carry ? hi_sum1_p1[k*BLK +: BLK] : hi_sum0_p1[k*BLK +: BLK];
            carry               = carry ? hi_c1_p1[k] : hi_c0_p1[k];
        end
        of_raw = (meta_p1.sign_a == meta_p1.sign_b) && (s_raw[WIDTH-1] != meta_p1.sign_a);
`ifdef PIPELINED_SELECT_ADDER_SAT_EN
        s_fin  = saturate(s_raw, of_raw, meta_p1.sign_a);
`else
        s_fin  = s_raw;
`endif
    end

    // ---- stage 2: resolved result, held while the consumer stalls ----
    logic [WIDTH-1:0] s_p2;
    logic             cout_p2;
    logic             of_p2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            s_p2    <= '0;
            cout_p2 <= 1'b0;
            of_p2   <= 1'b0;
        end else if (s2_free) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                s_p2    <= s_fin;
                cout_p2 <= carry;
                of_p2   <= of_raw;
            end
        end
    end

    assign out_valid = vld_p2;
    assign s         = s_p2;
    assign cout      = cout_p2;
    assign of        = of_p2;

endmodule

// File: tb/tb_pipelined_select_adder.sv
// Scoreboard bench for pipelined_select_adder (WIDTH=32, BLK=8): directed
// vectors, latency, backpressure and mid-operation reset.
module tb_pipelined_select_adder;

    localparam int W = 32;

`ifdef PIPELINED_SELECT_ADDER_SAT_EN
    localparam logic [W-1:0] E_POS_OVF = 32'h7FFF_FFFF;
    localparam logic [W-1:0] E_SUB_OVF = 32'h8000_0000;
    localparam logic [W-1:0] E_NEG_OVF = 32'h8000_0000;
`else
    localparam logic [W-1:0] E_POS_OVF = 32'h8000_0000;
    localparam logic [W-1:0] E_SUB_OVF = 32'h7FFF_FFFF;
    localparam logic [W-1:0] E_NEG_OVF = 32'h0000_0000;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] s;
    logic         cout;
    logic         of;

    always #5 clk = ~clk;

    pipelined_select_adder #(
        .WIDTH (32),
        .BLK   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .of        (of)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   results = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer seen at the negedge completes on the next posedge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=%h expected=none at %0t", s, $time);
                end else begin
                    e = sb.pop_front();
                    results++;
                    check("res_s", s, e.s);
                    check("res_cout", W'(cout), W'(e.c));
                    check("res_of", W'(of), W'(e.o));
                end
            end
        end
    end

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input vec_t v);
        exp_t e;
        bit   done;
        done     = 1'b0;
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        sub      = v.sub;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.s = v.es;
                e.c = v.ec;
                e.o = v.eo;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready_low expected=accept at %0t", $time);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (sb.size() != 0); i++) begin
            cycle(1);
        end
        check("drain_empty", W'(sb.size()), '0);
    endtask

    vec_t vecs[10];
    vec_t bp[4];
    vec_t v0;
    logic [W-1:0] held;

    initial begin
        vecs = '{
            '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, E_POS_OVF,    1'b0, 1'b1},
            '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0},
            '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, E_SUB_OVF,    1'b1, 1'b1},
            '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0},
            '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0},
            '{32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0},
            '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0},
            '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, E_NEG_OVF,    1'b1, 1'b1},
            '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0},
            '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0}
        };
        bp = '{
            '{32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0, 32'h0000_0033, 1'b0, 1'b0},
            '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0},
            '{32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_00FF, 1'b1, 1'b0},
            '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0}
        };
        v0 = '{32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0003, 1'b0, 1'b0};

        // Reset state
        cycle(2);
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_s", s, '0);
        check("rst_cout", W'(cout), '0);
        check("rst_of", W'(of), '0);
        check("rst_in_ready", W'(in_ready), '0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", W'(in_ready), W'(1));
        out_ready = 1'b1;

        // Two-cycle latency on the first transfer
        send(v0);
        in_valid = 1'b0;
        check("lat_cycle1", W'(out_valid), '0);
        cycle(1);
        check("lat_cycle2", W'(out_valid), W'(1));
        cycle(2);

        // Back-to-back directed vectors
        foreach (vecs[i]) send(vecs[i]);
        in_valid = 1'b0;
        drain();

        // Backpressure: stall the consumer for 3 cycles at the first result
        fork
            begin
                foreach (bp[i]) send(bp[i]);
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 50 && !out_valid; i++) cycle(1);
                out_ready = 1'b0;
                held = s;
                repeat (3) begin
                    cycle(1);
                    check("bp_hold_s", s, held);
                    check("bp_hold_valid", W'(out_valid), W'(1));
                    check("bp_in_ready", W'(in_ready), '0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("result_count", W'(results), W'(15));

        // Reset with both stages full discards the in-flight pair
        out_ready = 1'b0;
        a = 32'h0000_1000;
        b = 32'h0000_2000;
        cin = 1'b0;
        sub = 1'b0;
        in_valid = 1'b1;
        cycle(3);
        check("full_in_ready", W'(in_ready), '0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        cycle(1);
        check("midrst_out_valid", W'(out_valid), '0);
        check("midrst_in_ready", W'(in_ready), '0);
        rst_n = 1'b1;
        #1;
        check("midrel_in_ready", W'(in_ready), W'(1));
        out_ready = 1'b1;
        cycle(6);
        check("no_stale_valid", W'(out_valid), '0);
        check("no_stale_count", W'(results), W'(15));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
